btn_debounce: RTL and testbench

//   Input-side companion to the LED drivers: synchronises, polarity-normalises and

---
 rtl/btn_debounce.sv | 130 +++++++++++++
 tb/tb_btn_debounce.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchroniser, polarity normalisation and per-button debounce
// with one-cycle press/release strobes. Define BTN_AUTOREPEAT_EN to add held-button auto-repeat.
module btn_debounce #(
  parameter int                NBTN            = 7,
  parameter logic [NBTN-1:0]   ACTIVE_LOW_MASK = 7'b0000001,
  parameter int                DEBOUNCE_CYCLES = 250000,
  parameter int                REPEAT_DELAY    = 12500000,
  parameter int                REPEAT_RATE     = 2500000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NBTN-1:0] i_btn,
  output logic [NBTN-1:0] o_level,
  output logic [NBTN-1:0] o_press,
  output logic [NBTN-1:0] o_release
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_level;
  logic [NBTN-1:0] r_press;
  logic [NBTN-1:0] r_release;
  logic [CW-1:0]   r_cnt [NBTN];

  logic [NBTN-1:0] w_s;
  logic [NBTN-1:0] w_accept;
  logic [NBTN-1:0] w_rep_fire;

  // Sync flops reset to the idle pin level so a released button never looks pressed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= ACTIVE_LOW_MASK;
      r_sync2 <= ACTIVE_LOW_MASK;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW_MASK;

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NBTN; i++) begin
      w_accept[i] = (w_s[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (w_s[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_level[i] <= w_s[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW         = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]   r_rcnt [NBTN];
  logic [NBTN-1:0] r_rphase;

  // r_rphase selects the first (delay) interval versus the steady repeat interval.
  // A repeat coinciding with an accepted release is dropped.
  always_comb begin
    w_rep_fire = '0;
    for (int i = 0; i < NBTN; i++) begin
      w_rep_fire[i] = r_level[i] && !w_accept[i] &&
                      (r_rcnt[i] == (r_rphase[i] ? RATE_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rphase <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (!r_level[i] || w_accept[i]) begin
          r_rcnt[i]   <= '0;
          r_rphase[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rcnt[i]   <= '0;
          r_rphase[i] <= 1'b1;
        end else begin
          r_rcnt[i] <= r_rcnt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  // Strobes are registered alongside r_level so they line up with the level change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= (w_accept & w_s) | w_rep_fire;
      r_release <= w_accept & ~w_s;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: strobe events are queued with their expected cycle
// as stimulus is applied and checked as they appear; levels are checked at key points.
module tb_btn_debounce;

  localparam int NBTN = 7;
  localparam int DC   = 8;
  localparam int LAT  = DC + 2;  // negedge drive to visible strobe, in tb cycles
  localparam int EW   = 32 + 2 * NBTN;

  logic            clk = 1'b0;
  logic            rst;
  logic [NBTN-1:0] i_btn;
  logic [NBTN-1:0] o_level;
  logic [NBTN-1:0] o_press;
  logic [NBTN-1:0] o_release;

  logic [31:0]     cyc = '0;
  logic [EW-1:0]   exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [31:0]     c;
  logic [31:0]     p;

  btn_debounce #(
    .NBTN            (NBTN),
    .ACTIVE_LOW_MASK (7'b0000001),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (40),
    .REPEAT_RATE     (10)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn     (i_btn),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_ev(input logic [31:0] at, input logic [NBTN-1:0] pr,
                         input logic [NBTN-1:0] rl);
    exp_q.push_back({at, pr, rl});
  endtask

  initial begin
    rst   = 1'b1;
    i_btn = 7'b0000001;

    // Strobe monitor: every strobe must match the head of the queue, and a queued
    // event whose cycle has arrived without a strobe is reported as missing.
    fork
      forever begin
        logic [EW-1:0] got;
        logic [EW-1:0] expw;
        @(negedge clk);
        if ((o_press | o_release) != '0) begin
          got  = {cyc, o_press, o_release};
          expw = (exp_q.size() != 0) ? exp_q.pop_front() : {cyc, {2*NBTN{1'b0}}};
          n_cmp++;
          assert (got === expw) else begin
            n_err++;
            $error("FAIL strobe: observed cyc=%0d p=%b r=%b expected cyc=%0d p=%b r=%b",
                   got[EW-1:2*NBTN], got[2*NBTN-1:NBTN], got[NBTN-1:0],
                   expw[EW-1:2*NBTN], expw[2*NBTN-1:NBTN], expw[NBTN-1:0]);
          end
        end else if (exp_q.size() != 0 && exp_q[0][EW-1:2*NBTN] <= cyc) begin
          expw = exp_q.pop_front();
          got  = {expw[EW-1:2*NBTN], o_press, o_release};
          n_cmp++;
          assert (got === expw) else begin
            n_err++;
            $error("FAIL missing_strobe: observed p=%b r=%b expected cyc=%0d p=%b r=%b",
                   o_press, o_release, expw[EW-1:2*NBTN],
                   expw[2*NBTN-1:NBTN], expw[NBTN-1:0]);
          end
        end
      end
    join_none

    // Reset with PWR button idle-high
    tick(3);
    check("rst_level", 32'(o_level), 32'h0);
    check("rst_press", 32'(o_press), 32'h0);
    check("rst_release", 32'(o_release), 32'h0);
    rst = 1'b0;
    tick(50);
    check("idle_level", 32'(o_level), 32'h0);

    // Clean press on btn[1]
    c = cyc; i_btn[1] = 1'b1;
    push_ev(c + LAT, 7'b0000010, 7'b0);
    tick(LAT - 1);
    check("clean_before", 32'(o_level[1]), 32'h0);
    tick(1);
    check("clean_level", 32'(o_level[1]), 32'h1);
    check("clean_press", 32'(o_press), 32'h2);
    tick(1);
    check("clean_press_gone", 32'(o_press), 32'h0);
    tick(5);
    c = cyc; i_btn[1] = 1'b0;
    push_ev(c + LAT, 7'b0, 7'b0000010);
    tick(LAT + 2);

    // Bounce on btn[2]: short highs never accepted
    for (int j = 0; j < 4; j++) begin
      i_btn[2] = 1'b1; tick(5);
      i_btn[2] = 1'b0; tick(2);
    end
    c = cyc; i_btn[2] = 1'b1;
    push_ev(c + LAT, 7'b0000100, 7'b0);
    tick(LAT - 1);
    check("bounce_before", 32'(o_level[2]), 32'h0);
    tick(1);
    check("bounce_level", 32'(o_level[2]), 32'h1);
    tick(5);
    c = cyc; i_btn[2] = 1'b0;
    push_ev(c + LAT, 7'b0, 7'b0000100);
    tick(LAT + 2);

    // Active-low PWR button
    c = cyc; i_btn[0] = 1'b0;
    push_ev(c + LAT, 7'b0000001, 7'b0);
    tick(20);
    check("pwr_level", 32'(o_level[0]), 32'h1);
    c = cyc; i_btn[0] = 1'b1;
    push_ev(c + LAT, 7'b0, 7'b0000001);
    tick(LAT - 1);
    check("pwr_before_release", 32'(o_level[0]), 32'h1);
    tick(1);
    check("pwr_released", 32'(o_level[0]), 32'h0);
    check("pwr_release_strobe", 32'(o_release), 32'h1);
    tick(2);

    // Simultaneous press on btn[6:3]
    c = cyc; i_btn[6:3] = 4'hF;
    push_ev(c + LAT, 7'b1111000, 7'b0);
    tick(LAT);
    check("simul_press", 32'(o_press), 32'h78);
    tick(5);

    // New press on btn[1], async reset once its counter reaches 4
    i_btn[1] = 1'b1;
    tick(6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", 32'(o_level), 32'h0);
    check("async_rst_press", 32'(o_press), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    push_ev(c + LAT, 7'b1111010, 7'b0);
    tick(LAT);
    check("held_through_rst", 32'(o_level), 32'h7A);
    tick(3);
    c = cyc; i_btn = 7'b0000001;
    push_ev(c + LAT, 7'b0, 7'b1111010);
    tick(LAT + 2);

    // Long hold on btn[1]
    c = cyc; i_btn[1] = 1'b1;
    p = c + LAT;
    push_ev(p, 7'b0000010, 7'b0);
`ifdef BTN_AUTOREPEAT_EN
    for (int j = 40; j < 100; j += 10) push_ev(p + j, 7'b0000010, 7'b0);
`endif
    tick(100);
    c = cyc; i_btn[1] = 1'b0;
    push_ev(c + LAT, 7'b0, 7'b0000010);
    tick(LAT + 5);
    check("hold_released", 32'(o_level), 32'h0);

    tick(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
